axis_s_fifo: RTL

//   AXI-Stream slave stage directly downstream of the stream master (axis_m).

---
 rtl/axis_pkg.sv | 13 +
 rtl/axis_s_fifo_mem.sv | 29 ++
 rtl/axis_s_fifo.sv | 113 +++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions used by the stream master and the slave FIFO.
// Each FIFO entry stores {last, data}, so an entry is one bit wider than tdata.
package axis_pkg;

  localparam int AXIS_DATA_W  = 32;
  localparam int AXIS_ENTRY_W = AXIS_DATA_W + 1;

  typedef struct packed {
    logic                   last;
    logic [AXIS_DATA_W-1:0] data;
  } axis_entry_t;

endpackage : axis_pkg

// File: rtl/axis_s_fifo_mem.sv
// Storage array for the AXI-Stream slave FIFO: one synchronous write port
// and one asynchronous read port so the head entry is always presented
// (show-ahead). Pointer, flag and handshake logic live in the parent.
module axis_s_fifo_mem #(
  parameter int ENTRY_W = 33,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               aclk,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [ENTRY_W-1:0] o_rd_data
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  // Write the accepted beat into its slot on the clock edge.
  always_ff @(posedge aclk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Head entry is read combinationally so it is visible as soon as it is written.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule : axis_s_fifo_mem

// File: rtl/axis_s_fifo.sv
// AXI-Stream slave FIFO: accepts {tlast,tdata} beats on handshake, buffers
// them in a DEPTH-entry FIFO and offers a show-ahead pop interface.
// tready is deasserted while full; pkt_done pulses once per accepted tlast.
// Optional feature macro AXIS_S_PKT_CNT_EN adds a 16-bit wrapping packet
// counter (pkt_cnt) with a synchronous clear input (pkt_cnt_clr).
module axis_s_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              tvalid,
  input  logic              tlast,
  input  logic [DATA_W-1:0] tdata,
  output logic              tready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              empty,
  output logic [ADDR_W:0]   level,
`ifdef AXIS_S_PKT_CNT_EN
  input  logic              pkt_cnt_clr,
  output logic [15:0]       pkt_cnt,
`endif
  output logic              pkt_done
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic            r_pkt_done;

  logic            w_full;
  logic            w_empty;
  logic            w_wr;
  logic            w_rd;
  logic [DATA_W:0] w_wr_entry;
  logic [DATA_W:0] w_rd_entry;

  // Flags derive only from registered pointers, keeping tready free of input paths.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  // A pop in the same cycle as full does not open the slot; tready rises next cycle.
  assign w_wr = tvalid & ~w_full;
  assign w_rd = rd_en & ~w_empty;

  assign w_wr_entry = {tlast, tdata};

  // Advance pointers on accepted writes and pops; reset flushes the FIFO.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // One-cycle pulse after a tlast beat is accepted.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_pkt_done <= 1'b0;
    end else begin
      r_pkt_done <= w_wr & tlast;
    end
  end

`ifdef AXIS_S_PKT_CNT_EN
  logic [15:0] r_pkt_cnt;

  // Count accepted tlast beats; clear wins over increment, wraps naturally.
  always_ff @(posedge aclk) begin
    if (rst || pkt_cnt_clr) begin
      r_pkt_cnt <= '0;
    end else if (w_wr && tlast) begin
      r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

  axis_s_fifo_mem #(
    .ENTRY_W (DATA_W + 1),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_mem (
    .aclk      (aclk),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (w_rd_entry)
  );

  assign tready   = ~w_full;
  assign empty    = w_empty;
  assign level    = r_wr_ptr - r_rd_ptr;
  assign rd_data  = w_rd_entry[DATA_W-1:0];
  assign rd_last  = w_rd_entry[DATA_W];
  assign pkt_done = r_pkt_done;

endmodule : axis_s_fifo
